// File: rtl/wb_slave_regs_if.sv
// Wishbone B4 classic bus bundle between an initiator and the register-file responder.
// Signal names keep the responder's point of view (_i into the slave, _o out of it).
interface wb_slave_regs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                      cyc_i;
    logic                      stb_i;
    logic                      we_i;
    logic [ADDR_WIDTH-1:0]     adr_i;
    logic [DATA_WIDTH-1:0]     dat_i;
    logic [DATA_WIDTH/8-1:0]   sel_i;
    logic [DATA_WIDTH-1:0]     dat_o;
    logic                      ack_o;
    logic                      err_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_slave_regs.sv
// Wishbone B4 classic responder with a small byte-writable register file.
// Register 0 is a constant ID word; every register is also exported flat on regs_o.
module wb_slave_regs #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hCAFE_0001
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    wb_slave_regs_if.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] adr_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] dat_reg;
    logic [SEL_WIDTH-1:0]  sel_reg;

    logic                  req;
    logic                  enter_resp;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_adr;
    logic                  wr_we;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [SEL_WIDTH-1:0]  wr_sel;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];

    function automatic logic is_bad(input logic [ADDR_WIDTH-1:0] adr, input logic we);
        return (32'(adr) >= 32'(NUM_REGS)) || (we && (adr == '0));
    endfunction

    assign req = bus.cyc_i & bus.stb_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            adr_reg   <= '0;
            we_reg    <= 1'b0;
            dat_reg   <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && req) begin
                adr_reg <= bus.adr_i;
                we_reg  <= bus.we_i;
                dat_reg <= bus.dat_i;
                sel_reg <= bus.sel_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_WIDTH'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!req)
                    state_next = ST_IDLE;
                else if (cnt_reg == '0)
                    state_next = ST_RESP;
                else
                    cnt_next = cnt_reg - CNT_WIDTH'(1);
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // With zero wait states RESP is entered straight from IDLE, so the commit
    // has to use the live bus fields rather than the not-yet-latched copies.
    assign wr_adr     = (state_reg == ST_IDLE) ? bus.adr_i : adr_reg;
    assign wr_we      = (state_reg == ST_IDLE) ? bus.we_i  : we_reg;
    assign wr_dat     = (state_reg == ST_IDLE) ? bus.dat_i : dat_reg;
    assign wr_sel     = (state_reg == ST_IDLE) ? bus.sel_i : sel_reg;
    assign enter_resp = (state_next == ST_RESP);
    assign wr_en      = enter_resp && wr_we && !is_bad(wr_adr, wr_we);

    assign reg_val[0] = ID_VALUE;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_WIDTH-1:0] data_reg;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                data_reg <= '0;
            end else if (wr_en && (wr_adr == ADDR_WIDTH'(gi))) begin
                for (int b = 0; b < SEL_WIDTH; b++)
                    if (wr_sel[b])
                        data_reg[b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
        end

        assign reg_val[gi] = data_reg;
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_export
        assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = reg_val[gi];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (adr_reg == ADDR_WIDTH'(i))
                rd_data = reg_val[i];
    end

    always_comb begin
        bus.ack_o = 1'b0;
        bus.err_o = 1'b0;
        bus.dat_o = '0;
        if (state_reg == ST_RESP) begin
            if (is_bad(adr_reg, we_reg)) begin
                bus.err_o = 1'b1;
            end else begin
                bus.ack_o = 1'b1;
                if (!we_reg)
                    bus.dat_o = rd_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_slave_regs.sv
// Bench for wb_slave_regs: a transaction-level model of the responder checked every
// cycle against the default instance, plus directed checks on a zero-wait-state instance.
module tb_wb_slave_regs;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 8;
    localparam int WS = 2;
    localparam logic [31:0] ID = 32'hCAFE_0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    wb_slave_regs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    wb_slave_regs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    logic [NR*DW-1:0] regs;
    logic [NR*DW-1:0] regs0;

    wb_slave_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                    .WAIT_STATES(WS), .ID_VALUE(ID)) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(bus), .regs_o(regs));

    wb_slave_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                    .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus0), .regs_o(regs0));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: registers plus the one outstanding request on the default bus.
    logic [31:0] m_regs [NR];
    logic        m_ack = 1'b0, m_err = 1'b0;
    logic [31:0] m_dat = '0;
    bit          pending = 0, hold_off = 0, resolve_now;
    int          edge_n = 0, due = 0, cap_adr = 0;
    logic        cap_we;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_regs[0] = ID;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                foreach (m_regs[i]) m_regs[i] = '0;
                m_regs[0] = ID;
                pending = 0; hold_off = 0;
                m_ack = 0; m_err = 0; m_dat = '0;
            end else begin
                edge_n++;
                m_ack = 0; m_err = 0; m_dat = '0;
                resolve_now = 0;
                if (pending) begin
                    if (!(bus.cyc_i && bus.stb_i)) pending = 0;
                    else if (edge_n == due) resolve_now = 1;
                end else if (!hold_off && bus.cyc_i && bus.stb_i) begin
                    cap_adr = int'(bus.adr_i);
                    cap_we  = bus.we_i;
                    cap_dat = bus.dat_i;
                    cap_sel = bus.sel_i;
                    due     = edge_n + WS;
                    pending = 1;
                    if (WS == 0) resolve_now = 1;
                end
                hold_off = 0;
                if (resolve_now) begin
                    if (cap_adr >= NR || (cap_we && cap_adr == 0)) begin
                        m_err = 1;
                    end else begin
                        m_ack = 1;
                        if (cap_we) begin
                            for (int b = 0; b < 4; b++)
                                if (cap_sel[b]) m_regs[cap_adr][b*8 +: 8] = cap_dat[b*8 +: 8];
                        end else begin
                            m_dat = m_regs[cap_adr];
                        end
                    end
                    pending  = 0;
                    hold_off = 1;
                end
            end
        end
    end

    initial begin
        logic [255:0] exp_regs;
        forever begin
            @(negedge clk);
            if (started) begin
                exp_regs = '0;
                for (int i = 0; i < NR; i++) exp_regs[i*32 +: 32] = m_regs[i];
                chk("cyc_ack", bus.ack_o, m_ack);
                chk("cyc_err", bus.err_o, m_err);
                chk("cyc_dat", bus.dat_o, m_dat);
                chk("cyc_regs", regs, exp_regs);
            end
        end
    end

    task automatic drive(input bit d0, input logic cyc, input logic we, input logic [3:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (d0) begin
            bus0.cyc_i = cyc; bus0.stb_i = cyc; bus0.we_i = we;
            bus0.adr_i = adr; bus0.dat_i = dat; bus0.sel_i = sel;
        end else begin
            bus.cyc_i = cyc; bus.stb_i = cyc; bus.we_i = we;
            bus.adr_i = adr; bus.dat_i = dat; bus.sel_i = sel;
        end
    endtask

    // One transfer; lat counts edges from the sampling edge (1) to the response, 0 = none.
    task automatic xfer(input bit d0, input logic we, input logic [3:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int drop_after, input bit scramble,
                        output int lat, output logic ack, output logic err, output logic [31:0] rd);
        logic a, e;
        logic [31:0] d;
        @(negedge clk);
        drive(d0, 1'b1, we, adr, dat, sel);
        lat = 0; ack = 0; err = 0; rd = '0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            a = d0 ? bus0.ack_o : bus.ack_o;
            e = d0 ? bus0.err_o : bus.err_o;
            d = d0 ? bus0.dat_o : bus.dat_o;
            if (a || e) begin
                lat = n; ack = a; err = e; rd = d;
                break;
            end
            if (scramble && n == 1) drive(d0, 1'b1, ~we, 4'hF, ~dat, ~sel);
            if (drop_after > 0 && n == drop_after) drive(d0, 1'b0, 1'b0, 4'h0, '0, '0);
        end
        drive(d0, 1'b0, 1'b0, 4'h0, '0, '0);
        @(posedge clk);
    endtask

    initial begin
        int lat;
        logic ack, err;
        logic [31:0] rd;
        logic [255:0] rst_regs;
        rst_regs = '0;
        rst_regs[31:0] = ID;
        drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
        drive(1, 1'b0, 1'b0, 4'h0, '0, '0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", bus.ack_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_dat", bus.dat_o, 32'h0);
        chk("rst_regs", regs, rst_regs);
        rst_n = 1'b1;
        started = 1'b1;

        xfer(0, 1'b0, 4'd0, '0, 4'h0, 0, 0, lat, ack, err, rd);
        chk("id_lat", lat, 3);
        chk("id_ack", ack, 1'b1);
        chk("id_err", err, 1'b0);
        chk("id_dat", rd, 32'hCAFE_0001);

        xfer(0, 1'b1, 4'd3, 32'h1234_5678, 4'hF, 0, 0, lat, ack, err, rd);
        chk("wr3_ack", ack, 1'b1);
        xfer(0, 1'b0, 4'd3, '0, 4'h0, 0, 0, lat, ack, err, rd);
        chk("rd3_dat", rd, 32'h1234_5678);
        chk("rd3_regs", regs[127:96], 32'h1234_5678);

        xfer(0, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 0, 1, lat, ack, err, rd);
        chk("wr3_lane_lat", lat, 3);
        xfer(0, 1'b0, 4'd3, '0, 4'h0, 0, 0, lat, ack, err, rd);
        chk("rd3_lane_dat", rd, 32'h12BB_56DD);

        xfer(0, 1'b1, 4'd3, 32'h0000_0000, 4'h0, 0, 0, lat, ack, err, rd);
        chk("sel0_ack", ack, 1'b1);
        chk("sel0_regs", regs[127:96], 32'h12BB_56DD);

        xfer(0, 1'b0, 4'd9, '0, 4'hF, 0, 0, lat, ack, err, rd);
        chk("rd9_err", err, 1'b1);
        chk("rd9_ack", ack, 1'b0);
        chk("rd9_dat", rd, 32'h0);
        xfer(0, 1'b1, 4'd0, 32'h0, 4'hF, 0, 0, lat, ack, err, rd);
        chk("wr0_err", err, 1'b1);
        chk("wr0_regs", regs[31:0], 32'hCAFE_0001);

        xfer(0, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 1, 0, lat, ack, err, rd);
        chk("abort_lat", lat, 0);
        chk("abort_regs", regs[95:64], 32'h0);

        // Reset while a write to reg 4 sits in WAIT.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd4, 32'h5555_AAAA, 4'hF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", bus.ack_o, 1'b0);
        chk("arst_err", bus.err_o, 1'b0);
        chk("arst_dat", bus.dat_o, 32'h0);
        chk("arst_reg3", regs[127:96], 32'h0);
        chk("arst_reg0", regs[31:0], ID);
        drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_reg4", regs[159:128], 32'h0);

        xfer(1, 1'b0, 4'd0, '0, 4'h0, 0, 0, lat, ack, err, rd);
        chk("ws0_id_lat", lat, 1);
        chk("ws0_id_dat", rd, ID);
        xfer(1, 1'b1, 4'd5, 32'h0BAD_F00D, 4'b1100, 0, 0, lat, ack, err, rd);
        chk("ws0_wr_lat", lat, 1);
        chk("ws0_wr_ack", ack, 1'b1);
        xfer(1, 1'b0, 4'd5, '0, 4'h0, 0, 0, lat, ack, err, rd);
        chk("ws0_rd_dat", rd, 32'h0BAD_0000);
        chk("ws0_regs", regs0[191:160], 32'h0BAD_0000);
        xfer(1, 1'b1, 4'd0, 32'h1, 4'hF, 0, 0, lat, ack, err, rd);
        chk("ws0_wr0_err", err, 1'b1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
